// File: rtl/tl_mgr_pkg.sv
// Shared definitions for the manager-side TileLink transaction slots.
package tl_mgr_pkg;

  // Encoding 2'd3 is never produced; slots decode it as free.
  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_ALLOC    = 2'd1,
    SLOT_WAIT_FIN = 2'd2
  } slot_state_e;

  localparam int unsigned NXACT_DEF      = 4;
  localparam logic        MANAGER_ID_DEF = 1'b0;

  // manager_xact_id width for a given slot count (at least one bit).
  function automatic int unsigned xact_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/finish_slot.sv
// One manager transaction slot: lifecycle state plus Finish watchdog.
module finish_slot
  import tl_mgr_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic alloc_hit_i,
  input  logic grant_hit_i,
  input  logic needs_ack_i,
  input  logic finish_hit_i,
  output logic is_free_o,
  output logic free_nxt_o,
  output logic timeout_o,
  output logic illegal_o
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  slot_state_e          state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  // State and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SLOT_FREE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state, watchdog update and per-slot protocol checks, all judged
  // against the pre-edge state (so Grant+Finish in one cycle flags the Finish).
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_o = 1'b0;
    illegal_o = 1'b0;
    case (state_q)
      SLOT_ALLOC: begin
        if (grant_hit_i) begin
          state_d = needs_ack_i ? SLOT_WAIT_FIN : SLOT_FREE;
          wd_d    = '0;
        end
        illegal_o = finish_hit_i;
      end
      SLOT_WAIT_FIN: begin
        if (wd_q != WD_MAX) wd_d = wd_q + WD_ONE;
        // Fires on the step that lands on all ones; saturation keeps it single.
        timeout_o = (wd_q == (WD_MAX - WD_ONE)) && !finish_hit_i;
        if (finish_hit_i) begin
          state_d = SLOT_FREE;
          wd_d    = '0;
        end
        illegal_o = grant_hit_i;
      end
      default: begin
        if (alloc_hit_i) state_d = SLOT_ALLOC;
        wd_d      = '0;
        illegal_o = grant_hit_i | finish_hit_i;
      end
    endcase
  end

  assign is_free_o  = (state_q != SLOT_ALLOC) && (state_q != SLOT_WAIT_FIN);
  assign free_nxt_o = (state_d != SLOT_ALLOC) && (state_d != SLOT_WAIT_FIN);

endmodule

// File: rtl/finish_tracker.sv
// Manager-side Finish receiver: owns NXACT transaction slots, hands out free
// IDs and frees ack-required slots when their Finish arrives.
module finish_tracker
  import tl_mgr_pkg::*;
#(
  parameter int unsigned NXACT      = NXACT_DEF,
  parameter int unsigned XACT_W     = xact_w(NXACT),
  parameter logic        MANAGER_ID = MANAGER_ID_DEF,
  parameter int unsigned TIMEOUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_ready,
  output logic              alloc_valid,
  output logic [XACT_W-1:0] alloc_xact_id,
  input  logic              grant_valid,
  input  logic [XACT_W-1:0] grant_xact_id,
  input  logic              grant_needs_ack,
  output logic              finish_ready,
  input  logic              finish_valid,
  input  logic [XACT_W-1:0] finish_manager_xact_id,
  input  logic              finish_manager_id,
  output logic [NXACT-1:0]  free_mask,
  output logic [XACT_W:0]   busy_count,
  output logic              err_pulse,
  output logic              timeout_pulse
);

  logic [NXACT-1:0] alloc_hit, grant_hit, finish_hit;
  logic [NXACT-1:0] is_free, free_nxt, timeout, illegal;
  logic [XACT_W:0]  busy_q, busy_d;
  logic             finish_ready_q, err_q, err_d, tmo_q, tmo_d;
  logic             finish_acc, mgr_ok;
  logic [XACT_W-1:0] alloc_id;

  assign finish_acc = finish_valid & finish_ready_q;
  assign mgr_ok     = (finish_manager_id == MANAGER_ID);

  genvar g;
  generate
    for (g = 0; g < NXACT; g++) begin : g_slot
      assign alloc_hit[g]  = alloc_valid & alloc_ready & (alloc_id == XACT_W'(g));
      assign grant_hit[g]  = grant_valid & (grant_xact_id == XACT_W'(g));
      assign finish_hit[g] = finish_acc & mgr_ok & (finish_manager_xact_id == XACT_W'(g));

      finish_slot #(.TIMEOUT_W(TIMEOUT_W)) u_slot (
        .clk_i        (clk),
        .rst_ni       (reset),
        .alloc_hit_i  (alloc_hit[g]),
        .grant_hit_i  (grant_hit[g]),
        .needs_ack_i  (grant_needs_ack),
        .finish_hit_i (finish_hit[g]),
        .is_free_o    (is_free[g]),
        .free_nxt_o   (free_nxt[g]),
        .timeout_o    (timeout[g]),
        .illegal_o    (illegal[g])
      );
    end
  endgenerate

  // Lowest-numbered free slot; scanning downward lets the lowest win.
  always_comb begin
    alloc_id = '0;
    for (int i = NXACT - 1; i >= 0; i--) begin
      if (is_free[i]) alloc_id = XACT_W'(i);
    end
  end

  // Busy count tracks the slot states the next edge will load.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NXACT; i++) begin
      busy_d = busy_d + {{XACT_W{1'b0}}, ~free_nxt[i]};
    end
  end

  // Error causes: per-slot illegal events plus Finishes for another manager.
  always_comb begin
    err_d = (|illegal) | (finish_acc & ~mgr_ok);
    tmo_d = |timeout;
  end

  // Registered status; Finish is never back-pressured once out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish_ready_q <= 1'b0;
      busy_q         <= '0;
      err_q          <= 1'b0;
      tmo_q          <= 1'b0;
    end else begin
      finish_ready_q <= 1'b1;
      busy_q         <= busy_d;
      err_q          <= err_d;
      tmo_q          <= tmo_d;
    end
  end

  assign alloc_valid   = |is_free;
  assign alloc_xact_id = alloc_id;
  assign free_mask     = is_free;
  assign busy_count    = busy_q;
  assign finish_ready  = finish_ready_q;
  assign err_pulse     = err_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_finish_tracker.sv
// Directed bench for finish_tracker (NXACT=4, TIMEOUT_W=3).
module tb_finish_tracker;

  logic       clk, reset;
  logic       alloc_ready, alloc_valid;
  logic [1:0] alloc_xact_id;
  logic       grant_valid, grant_needs_ack;
  logic [1:0] grant_xact_id;
  logic       finish_ready, finish_valid, finish_manager_id;
  logic [1:0] finish_manager_xact_id;
  logic [3:0] free_mask;
  logic [2:0] busy_count;
  logic       err_pulse, timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  finish_tracker #(.NXACT(4), .XACT_W(2), .MANAGER_ID(1'b0), .TIMEOUT_W(3)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .alloc_ready            (alloc_ready),
    .alloc_valid            (alloc_valid),
    .alloc_xact_id          (alloc_xact_id),
    .grant_valid            (grant_valid),
    .grant_xact_id          (grant_xact_id),
    .grant_needs_ack        (grant_needs_ack),
    .finish_ready           (finish_ready),
    .finish_valid           (finish_valid),
    .finish_manager_xact_id (finish_manager_xact_id),
    .finish_manager_id      (finish_manager_id),
    .free_mask              (free_mask),
    .busy_count             (busy_count),
    .err_pulse              (err_pulse),
    .timeout_pulse          (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gnt(input logic v, input logic [1:0] id, input logic ack);
    grant_valid = v; grant_xact_id = id; grant_needs_ack = ack;
  endtask

  task automatic fin(input logic v, input logic [1:0] id, input logic mgr);
    finish_valid = v; finish_manager_xact_id = id; finish_manager_id = mgr;
  endtask

  task automatic idle();
    alloc_ready = 1'b0;
    gnt(1'b0, 2'd0, 1'b0);
    fin(1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b0;
    idle();
    #3;
    chk("rst alloc_valid", alloc_valid, 1);
    chk("rst alloc_id", alloc_xact_id, 0);
    chk("rst free_mask", free_mask, 4'hF);
    chk("rst busy", busy_count, 0);
    chk("rst finish_ready", finish_ready, 0);
    chk("rst err", err_pulse, 0);
    chk("rst timeout", timeout_pulse, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst held finish_ready", finish_ready, 0);
    reset = 1'b1;
    tick();
    chk("release finish_ready", finish_ready, 1);

    // Fill all four slots.
    alloc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill alloc_id", alloc_xact_id, i);
      chk("fill alloc_valid", alloc_valid, 1);
      tick();
    end
    alloc_ready = 1'b0;
    chk("full alloc_valid", alloc_valid, 0);
    chk("full busy", busy_count, 4);
    chk("full free_mask", free_mask, 0);

    // Grant without ack frees the slot next cycle.
    gnt(1'b1, 2'd2, 1'b0); tick(); idle();
    chk("g2 free_mask", free_mask, 4'b0100);
    chk("g2 alloc_id", alloc_xact_id, 2);
    chk("g2 busy", busy_count, 3);
    chk("g2 err", err_pulse, 0);

    gnt(1'b1, 2'd1, 1'b0); tick(); idle();
    chk("g1 free_mask", free_mask, 4'b0110);
    chk("g1 alloc_id", alloc_xact_id, 1);

    // Re-allocate slot 1, grant with ack, then finish it.
    alloc_ready = 1'b1; tick(); idle();
    chk("re-alloc free_mask", free_mask, 4'b0100);
    chk("re-alloc alloc_id", alloc_xact_id, 2);
    chk("re-alloc busy", busy_count, 3);
    gnt(1'b1, 2'd1, 1'b1); tick(); idle();
    chk("g1 ack free_mask", free_mask, 4'b0100);
    chk("g1 ack err", err_pulse, 0);
    fin(1'b1, 2'd1, 1'b0); tick(); idle();
    chk("fin1 free_mask", free_mask, 4'b0110);
    chk("fin1 busy", busy_count, 2);
    chk("fin1 err", err_pulse, 0);

    // Error cases: wrong manager_id, Finish to a FREE slot.
    gnt(1'b1, 2'd0, 1'b1); tick(); idle();
    chk("g0 ack err", err_pulse, 0);
    fin(1'b1, 2'd0, 1'b1); tick(); idle();
    chk("bad mgr err", err_pulse, 1);
    chk("bad mgr free_mask", free_mask, 4'b0110);
    chk("bad mgr finish_ready", finish_ready, 1);
    tick();
    chk("bad mgr err clears", err_pulse, 0);
    fin(1'b1, 2'd1, 1'b0); tick(); idle();
    chk("fin free err", err_pulse, 1);
    chk("fin free free_mask", free_mask, 4'b0110);
    chk("fin free busy", busy_count, 2);
    chk("fin free finish_ready", finish_ready, 1);
    tick();
    chk("fin free err clears", err_pulse, 0);
    chk("no early timeout", timeout_pulse, 0);
    fin(1'b1, 2'd0, 1'b0); tick(); idle();
    chk("fin0 free_mask", free_mask, 4'b0111);
    chk("fin0 busy", busy_count, 1);
    chk("fin0 err", err_pulse, 0);
    chk("fin0 timeout", timeout_pulse, 0);

    // Grant to a FREE slot.
    gnt(1'b1, 2'd2, 1'b0); tick(); idle();
    chk("g free err", err_pulse, 1);
    chk("g free free_mask", free_mask, 4'b0111);
    tick();
    chk("g free err clears", err_pulse, 0);

    // Grant(ack) and Finish to slot 3 together: Finish sees ALLOC.
    gnt(1'b1, 2'd3, 1'b1); fin(1'b1, 2'd3, 1'b0); tick(); idle();
    chk("g+f err", err_pulse, 1);
    chk("g+f free_mask", free_mask, 4'b0111);
    chk("g+f busy", busy_count, 1);

    // Watchdog reaches 7 seven edges after entering WAIT_FIN.
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("timeout step", timeout_pulse, (k == 7) ? 1 : 0);
    end
    chk("timeout keeps slot", free_mask, 4'b0111);
    fin(1'b1, 2'd3, 1'b0); tick(); idle();
    chk("late fin free_mask", free_mask, 4'hF);
    chk("late fin busy", busy_count, 0);
    chk("late fin err", err_pulse, 0);

    // Alloc, Grant and Finish on different slots in one cycle.
    alloc_ready = 1'b1; tick();
    gnt(1'b1, 2'd0, 1'b1); tick();
    gnt(1'b1, 2'd1, 1'b0); fin(1'b1, 2'd0, 1'b0);
    chk("multi alloc_id", alloc_xact_id, 2);
    tick(); idle();
    chk("multi free_mask", free_mask, 4'b1011);
    chk("multi busy", busy_count, 1);
    chk("multi err", err_pulse, 0);
    chk("multi alloc_id after", alloc_xact_id, 0);

    // Three slots into WAIT_FIN, then asynchronous reset mid-cycle.
    alloc_ready = 1'b1; gnt(1'b1, 2'd2, 1'b1); tick();
    gnt(1'b1, 2'd0, 1'b1); tick();
    alloc_ready = 1'b0; gnt(1'b1, 2'd1, 1'b1); tick(); idle();
    chk("pre-rst free_mask", free_mask, 4'b1000);
    chk("pre-rst busy", busy_count, 3);
    #2 reset = 1'b0;
    #1;
    chk("async rst free_mask", free_mask, 4'hF);
    chk("async rst busy", busy_count, 0);
    chk("async rst alloc_valid", alloc_valid, 1);
    chk("async rst alloc_id", alloc_xact_id, 0);
    chk("async rst finish_ready", finish_ready, 0);
    chk("async rst err", err_pulse, 0);
    #2 reset = 1'b1;
    fin(1'b1, 2'd2, 1'b0);
    tick();
    chk("post-rst finish_ready", finish_ready, 1);
    chk("post-rst err first", err_pulse, 0);
    tick(); idle();
    chk("stale fin err", err_pulse, 1);
    chk("stale fin free_mask", free_mask, 4'hF);
    tick();
    chk("stale fin err clears", err_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
